// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the two-digit BCD stopwatch/timer controller.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX           = 4'd9;
    localparam logic [3:0] COUNT_TOP_ONES    = 4'd9;
    localparam logic [3:0] COUNT_TOP_TENS    = 4'd9;
    localparam logic [3:0] COUNT_BOTTOM_ONES = 4'd0;
    localparam logic [3:0] COUNT_BOTTOM_TENS = 4'd0;

    // Non-BCD preset digits (A-F) load as 9 rather than producing an illegal digit.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_timer_ctrl_bcd2_updown.sv
// Two-digit BCD up/down counter with synchronous load (priority over enable).
// Callers gate the enable at 99/00; this block itself wraps digit-wise.
module bcd2_updown
    import bcd_timer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] load_ones_i,
    input  logic [3:0] load_tens_i,
    input  logic       en_i,
    input  logic       down_i,
    output logic [3:0] ones_o,
    output logic [3:0] tens_o,
    output logic       at_99_o,
    output logic       at_00_o
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (load_i) begin
            ones_d = load_ones_i;
            tens_d = load_tens_i;
        end else if (en_i && !down_i) begin
            if (ones_q == BCD_MAX) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (en_i && down_i) begin
            if (ones_q == 4'd0) begin
                ones_d = BCD_MAX;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones_o  = ones_q;
    assign tens_o  = tens_q;
    assign at_99_o = (ones_q == COUNT_TOP_ONES) && (tens_q == COUNT_TOP_TENS);
    assign at_00_o = (ones_q == COUNT_BOTTOM_ONES) && (tens_q == COUNT_BOTTOM_TENS);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Start/pause/clear sequencer and tick prescaler for a 00-99 BCD stopwatch/down-timer.
// Optional lap-hold display capture is built only when BCD_TIMER_LAP_EN is defined.
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    input  logic       mode_down,
    input  logic [3:0] preset_ones,
    input  logic [3:0] preset_tens,
    output logic [3:0] count_ones,
    output logic [3:0] count_tens,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [PW-1:0]   presc_q, presc_d;

    logic            cnt_load, cnt_en;
    logic [3:0]      cnt_load_ones, cnt_load_tens;
    logic [3:0]      live_ones, live_tens;
    logic [3:0]      pre_ones, pre_tens;
    logic            at_99, at_00;
    logic            tick_w, term_next;

    assign pre_ones = bcd_clamp(preset_ones);
    assign pre_tens = bcd_clamp(preset_tens);
    assign tick_w   = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    // Decide DONE on the stepping edge so done rises with the terminal value.
    assign term_next = mode_q ? ((live_tens == COUNT_BOTTOM_TENS) && (live_ones == 4'd1))
                              : ((live_tens == COUNT_TOP_TENS) && (live_ones == 4'd8));

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        presc_d       = presc_q;
        cnt_load      = 1'b0;
        cnt_load_ones = 4'd0;
        cnt_load_tens = 4'd0;
        cnt_en        = 1'b0;
        if (clear) begin
            state_d  = ST_IDLE;
            presc_d  = '0;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_stop) begin
                        mode_d   = mode_down;
                        presc_d  = '0;
                        cnt_load = 1'b1;
                        if (mode_down) begin
                            cnt_load_ones = pre_ones;
                            cnt_load_tens = pre_tens;
                        end
                        state_d = (mode_down && pre_ones == 4'd0 && pre_tens == 4'd0)
                                  ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick_w) begin
                        cnt_en  = !(mode_q ? at_00 : at_99);
                        presc_d = '0;
                        if (term_next)       state_d = ST_DONE;
                        else if (start_stop) state_d = ST_PAUSE;
                    end else begin
                        presc_d = presc_q + 1'b1;
                        if (start_stop) state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) state_d = ST_RUN;
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
        end
    end

    bcd2_updown u_cnt (
        .clock       (clock),
        .reset       (reset),
        .load_i      (cnt_load),
        .load_ones_i (cnt_load_ones),
        .load_tens_i (cnt_load_tens),
        .en_i        (cnt_en),
        .down_i      (mode_q),
        .ones_o      (live_ones),
        .tens_o      (live_tens),
        .at_99_o     (at_99),
        .at_00_o     (at_00)
    );

`ifdef BCD_TIMER_LAP_EN
    logic       hold_q, hold_d;
    logic [3:0] cap_ones_q, cap_ones_d;
    logic [3:0] cap_tens_q, cap_tens_d;

    always_comb begin
        hold_d     = hold_q;
        cap_ones_d = cap_ones_q;
        cap_tens_d = cap_tens_q;
        if (clear) begin
            hold_d = 1'b0;
        end else if (lap && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
            hold_d = !hold_q;
            if (!hold_q) begin
                cap_ones_d = live_ones;
                cap_tens_d = live_tens;
            end
        end
        if (state_d == ST_DONE) hold_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q     <= 1'b0;
            cap_ones_q <= 4'd0;
            cap_tens_q <= 4'd0;
        end else begin
            hold_q     <= hold_d;
            cap_ones_q <= cap_ones_d;
            cap_tens_q <= cap_tens_d;
        end
    end

    assign count_ones = hold_q ? cap_ones_q : live_ones;
    assign count_tens = hold_q ? cap_tens_q : live_tens;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign count_ones = live_ones;
    assign count_tens = live_tens;
`endif

    assign running = (state_q == ST_RUN);
    assign paused  = (state_q == ST_PAUSE);
    assign done    = (state_q == ST_DONE);
    assign tick    = tick_w;

endmodule
